// File: rtl/calc_pkg.sv
// Shared opcode/state encodings and flag bit positions for the accumulator unit.
package calc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_OR   = 4'h2,
    OP_AND  = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_SAR  = 4'h7,
    OP_NEG  = 4'h8,
    OP_NOT  = 4'h9,
    OP_REV  = 4'hA,
    OP_MUL  = 4'hB,
    OP_LOAD = 4'hC,
    OP_LTU  = 4'hD,
    OP_GTU  = 4'hE,
    OP_UNDO = 4'hF
  } opcode_e;

  typedef enum logic {IDLE, BUSY} state_e;

  localparam int FLAG_W = 4;
  localparam int FLG_C  = 3;
  localparam int FLG_V  = 2;
  localparam int FLG_N  = 1;
  localparam int FLG_Z  = 0;

endpackage

// File: rtl/calc_undo_stack.sv
// Circular LIFO of {acc, flags} snapshots; a push when full overwrites the oldest entry.
module calc_undo_stack
  import calc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int UNDO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic                              pop,
  input  logic [WIDTH+FLAG_W-1:0]           push_data,
  output logic [WIDTH+FLAG_W-1:0]           top_data,
  output logic [$clog2(UNDO_DEPTH+1)-1:0]   count
);

  localparam int PW = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
  localparam int CW = $clog2(UNDO_DEPTH+1);

  typedef struct packed {
    logic [WIDTH-1:0]  acc;
    logic [FLAG_W-1:0] flags;
  } undo_entry_t;

  undo_entry_t   mem [UNDO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(UNDO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(UNDO_DEPTH-1) : p - PW'(1);
  endfunction

  // wr_ptr always names the slot the next push lands in, so the newest entry sits one behind it.
  assign top_ptr  = ptr_dec(wr_ptr);
  assign top_data = mem[top_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < UNDO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= ptr_inc(wr_ptr);
      if (count != CW'(UNDO_DEPTH)) count <= count + CW'(1);
    end else if (pop && (count != '0)) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/calc_accum_unit.sv
// WIDTH-bit accumulator calculator with valid/ready issue, multi-cycle shift/multiply and undo history.
// state | meaning
// IDLE  | op_ready=1; single-cycle ops and UNDO complete on the accept edge
// BUSY  | shift or multiply in progress; counter runs down, acc/flags hold
module calc_accum_unit
  import calc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int UNDO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [3:0]                       opcode,
  input  logic [WIDTH-1:0]                 operand,
  output logic [WIDTH-1:0]                 acc,
  output logic [3:0]                       flags,
  output logic                             err,
  output logic [$clog2(UNDO_DEPTH+1)-1:0]  undo_count
);

  localparam int KW   = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH+1);

  typedef struct packed {
    logic [WIDTH-1:0]  acc;
    logic [FLAG_W-1:0] flags;
  } undo_entry_t;

  state_e               state_q, state_d;
  opcode_e              op, bop_q, bop_d;
  logic [WIDTH-1:0]     acc_q, acc_d, work_q, work_d, alu_res;
  logic [3:0]           flg_q, flg_d;
  logic                 err_q, err_d, alu_c, alu_v, c_step, push, pop;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, mcand_q, mcand_d;
  logic [WIDTH:0]       sum;
  logic [KW-1:0]        k;
  undo_entry_t          push_entry, undo_top;

  assign op         = opcode_e'(opcode);
  assign k          = operand[KW-1:0];
  assign push_entry = '{acc: acc_q, flags: flg_q};

  function automatic logic [3:0] mk_flags(input logic c, input logic v, input logic [WIDTH-1:0] r);
    logic [3:0] f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_N] = r[WIDTH-1];
    f[FLG_Z] = (r == '0);
    return f;
  endfunction

  always_comb begin
    alu_res = acc_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = '0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, acc_q} + {1'b0, operand};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (acc_q[WIDTH-1] == operand[WIDTH-1]) && (alu_res[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = acc_q - operand;
        alu_c   = operand > acc_q;
        alu_v   = (acc_q[WIDTH-1] != operand[WIDTH-1]) && (alu_res[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_OR:   alu_res = acc_q | operand;
      OP_AND:  alu_res = acc_q & operand;
      OP_XOR:  alu_res = acc_q ^ operand;
      OP_NEG: begin
        alu_res = '0 - acc_q;
        alu_v   = (acc_q == {1'b1, {(WIDTH-1){1'b0}}});
        alu_c   = |acc_q;
      end
      OP_NOT:  alu_res = ~acc_q;
      OP_REV:  for (int i = 0; i < WIDTH; i++) alu_res[i] = acc_q[WIDTH-1-i];
      OP_LOAD: alu_res = operand;
      OP_LTU:  alu_res = {{(WIDTH-1){1'b0}}, acc_q < operand};
      OP_GTU:  alu_res = {{(WIDTH-1){1'b0}}, acc_q > operand};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    flg_d    = flg_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    work_d   = work_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    bop_d    = bop_q;
    push     = 1'b0;
    pop      = 1'b0;
    c_step   = 1'b0;
    op_ready = (state_q == IDLE);
    case (state_q)
      IDLE: if (op_valid) begin
        push = (op != OP_UNDO);
        if (op == OP_UNDO) begin
          if (undo_count == '0) err_d = 1'b1;
          else begin
            pop   = 1'b1;
            acc_d = undo_top.acc;
            flg_d = undo_top.flags;
          end
        end else if ((op inside {OP_SHL, OP_SHR, OP_SAR}) && (k != '0)) begin
          state_d = BUSY;
          cnt_d   = CNTW'(k);
          work_d  = acc_q;
          bop_d   = op;
        end else if (op == OP_MUL) begin
          state_d = BUSY;
          cnt_d   = CNTW'(WIDTH);
          work_d  = operand;
          prod_d  = '0;
          mcand_d = {{WIDTH{1'b0}}, acc_q};
          bop_d   = op;
        end else begin
          acc_d = alu_res;
          flg_d = mk_flags(alu_c, alu_v, alu_res);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNTW'(1);
        case (bop_q)
          OP_SHL: begin c_step = work_q[WIDTH-1]; work_d = work_q << 1; end
          OP_SHR: begin c_step = work_q[0];       work_d = work_q >> 1; end
          OP_SAR: begin c_step = work_q[0];       work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; end
          OP_MUL: begin
            prod_d  = prod_q + (work_q[0] ? mcand_q : '0);
            mcand_d = mcand_q << 1;
            work_d  = work_q >> 1;
          end
          default: ;
        endcase
        // Terminal count: this edge takes the counter to zero and commits the result.
        if (cnt_q == CNTW'(1)) begin
          state_d = IDLE;
          if (bop_q == OP_MUL) begin
            acc_d = prod_d[WIDTH-1:0];
            flg_d = mk_flags(1'b0, |prod_d[2*WIDTH-1:WIDTH], prod_d[WIDTH-1:0]);
          end else begin
            acc_d = work_d;
            flg_d = mk_flags(c_step, 1'b0, work_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      bop_q   <= OP_ADD;
    end else begin
      acc_q   <= acc_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      bop_q   <= bop_d;
    end
  end

  calc_undo_stack #(
    .WIDTH      (WIDTH),
    .UNDO_DEPTH (UNDO_DEPTH)
  ) u_undo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .top_data  (undo_top),
    .count     (undo_count)
  );

  assign acc   = acc_q;
  assign flags = flg_q;
  assign err   = err_q;

endmodule

// File: tb/tb_calc_accum_unit.sv
// Bench for calc_accum_unit: directed plan steps plus random ops against an arithmetic reference model.
module tb_calc_accum_unit;

  localparam int WIDTH      = 8;
  localparam int UNDO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] opcode = '0;
  logic [7:0] operand = '0;
  logic [7:0] acc;
  logic [3:0] flags;
  logic       err;
  logic [2:0] undo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_acc   = 0;
  int m_flags = 0;
  int m_hist[$];

  calc_accum_unit #(.WIDTH(WIDTH), .UNDO_DEPTH(UNDO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .opcode     (opcode),
    .operand    (operand),
    .acc        (acc),
    .flags      (flags),
    .err        (err),
    .undo_count (undo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Result, {C,V,N,Z} flags and busy length of one non-UNDO op on an 8-bit accumulator.
  function automatic void model(input int op, input int a, input int b,
                                output int r, output int f, output int cyc);
    int c, v, k, p, sa, sb;
    c = 0; v = 0; cyc = 0; r = a;
    k = b & 7; sa = sgn(a); sb = sgn(b);
    case (op)
      0:  begin r = (a + b) & 255; c = int'(a + b > 255); v = int'((sa + sb > 127) || (sa + sb < -128)); end
      1:  begin r = (a - b) & 255; c = int'(b > a);       v = int'((sa - sb > 127) || (sa - sb < -128)); end
      2:  r = a | b;
      3:  r = a & b;
      4:  r = a ^ b;
      5:  begin r = (a << k) & 255;   c = (k != 0) ? (a >> (8 - k)) & 1 : 0;    cyc = k; end
      6:  begin r = a >> k;           c = (k != 0) ? (a >> (k - 1)) & 1 : 0;    cyc = k; end
      7:  begin r = (sa >>> k) & 255; c = (k != 0) ? (sa >>> (k - 1)) & 1 : 0;  cyc = k; end
      8:  begin r = (256 - a) & 255; v = int'(a == 128); c = int'(a != 0); end
      9:  r = 255 - a;
      10: begin r = 0; for (int i = 0; i < 8; i++) r = r | (((a >> i) & 1) << (7 - i)); end
      11: begin p = a * b; r = p & 255; v = int'(p > 255); cyc = 8; end
      12: r = b;
      13: r = int'(a < b);
      14: r = int'(a > b);
      default: ;
    endcase
    f = (c << 3) | (v << 2) | (((r >> 7) & 1) << 1) | int'(r == 0);
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_flags = 0;
    m_hist.delete();
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic run_op(input int op, input int b, input bit poke);
    int r, f, cyc, ent, busy, exp_err, pre_acc;
    busy = 0; exp_err = 0; pre_acc = m_acc;
    if (op == 15) begin
      cyc = 0;
      if (m_hist.size() == 0) begin
        exp_err = 1; r = m_acc; f = m_flags;
      end else begin
        ent = m_hist.pop_back();
        r = ent >> 4; f = ent & 15;
      end
    end else begin
      model(op, m_acc, b, r, f, cyc);
      m_hist.push_back((m_acc << 4) | m_flags);
      if (m_hist.size() > UNDO_DEPTH) void'(m_hist.pop_front());
    end
    chk("ready_before", op_ready, 1);
    op_valid = 1'b1; opcode = 4'(op); operand = 8'(b);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    chk("err_pulse", err, exp_err);
    while (op_ready !== 1'b1 && busy < 64) begin
      chk("acc_hold", acc, pre_acc);
      if (poke && busy == 3) begin
        op_valid = 1'b1; opcode = 4'hC; operand = 8'h55;
      end else op_valid = 1'b0;
      busy++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("busy_cycles", busy, cyc);
    chk("acc", acc, r);
    chk("flags", flags, f);
    chk("undo_count", undo_count, m_hist.size());
    if (busy == 0) @(negedge clk);
    chk("err_clear", err, 0);
    m_acc = r;
    m_flags = f;
  endtask

  initial begin
    int exp_undo[5];
    exp_undo = '{5, 4, 3, 2, 2};
    repeat (2) @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    chk("rst_undo", undo_count, 0);
    chk("rst_ready", op_ready, 1);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    run_op(12, 8'h7F, 0); run_op(0, 8'h01, 0);
    chk("t1_acc", acc, 8'h80); chk("t1_flags", flags, 4'b0110);

    run_op(12, 8'h05, 0); run_op(1, 8'h05, 0);
    chk("t2a_acc", acc, 8'h00); chk("t2a_flags", flags, 4'b0001);
    run_op(1, 8'h01, 0);
    chk("t2b_acc", acc, 8'hFF); chk("t2b_flags", flags, 4'b1010);

    run_op(12, 8'h12, 0); run_op(11, 8'h10, 1);
    chk("t3_acc", acc, 8'h20); chk("t3_flags", flags, 4'b0100);

    run_op(12, 8'h81, 0); run_op(5, 3, 0);
    chk("t4a_acc", acc, 8'h08); chk("t4a_flags", flags, 4'b0000);
    run_op(12, 8'h80, 0); run_op(7, 2, 0);
    chk("t4b_acc", acc, 8'hE0); chk("t4b_flags", flags, 4'b0010);
    run_op(6, 0, 0);
    chk("t4c_acc", acc, 8'hE0); chk("t4c_flags", flags, 4'b0010);

    for (int i = 1; i <= 6; i++) run_op(12, i, 0);
    chk("t5_full", undo_count, 4);
    for (int i = 0; i < 5; i++) begin
      run_op(15, 0, 0);
      chk("t5_undo_acc", acc, exp_undo[i]);
    end
    chk("t5_empty", undo_count, 0);

    for (int i = 0; i < 300; i++) run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 0);

    run_op(12, 8'h37, 0);
    op_valid = 1'b1; opcode = 4'hB; operand = 8'h03;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_acc", acc, 0);
    chk("t6_flags", flags, 0);
    chk("t6_undo", undo_count, 0);
    chk("t6_ready", op_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 8'h03, 0);
    chk("t6_add_acc", acc, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calc_accum_unit.md
Name: calc_accum_unit

Overview:
Parametrised successor to the 8-bit accumulator calculator. It holds a WIDTH-bit accumulator with registered C/V/N/Z flags and adds three things:
- valid/ready operation issue;
- multi-cycle ops (variable-amount shifts, shift-add multiply) with a busy phase;
- a UNDO_DEPTH-entry undo history that restores earlier accumulator and flag values.

It sits between the pad-level wrapper, which handles edge detection and pin muxing, and the output drivers.

Parameters:
WIDTH, 8, accumulator/operand width in bits (>=4, power of 2)
UNDO_DEPTH, 4, undo history entries (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
op_valid  in  1  operation request
op_ready  out  1  unit can accept op this cycle
opcode  in  4  operation select
operand  in  WIDTH  B operand
acc  out  WIDTH  accumulator value
flags  out  4  {C,V,N,Z}
err  out  1  one-cycle pulse: UNDO with empty history
undo_count  out  $clog2(UNDO_DEPTH+1)  valid history entries

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. Reset clears acc, flags, err and undo_count to 0, sets op_ready=1 and state=IDLE. Reset mid-operation aborts the op with no partial result.
- Accept occurs on a clk edge with op_valid && op_ready. opcode/operand are sampled only at accept. op_valid while op_ready=0 is ignored; the requester holds it.
- States:
  - IDLE: op_ready=1.
  - BUSY: op_ready=0; a down-counter and a work register run.
  - IDLE->BUSY on accept of a multi-cycle op with non-zero length. BUSY->IDLE on the edge where the counter reaches 0.
- Single-cycle ops update acc/flags on the accept edge, and op_ready stays 1.
  - 0 ADD: acc+op.
  - 1 SUB: acc-op.
  - 2 OR, 3 AND, 4 XOR.
  - 8 NEG: two's complement.
  - 9 NOT.
  - A REV: bit reverse.
  - C LOAD: acc=op.
  - D LTU: acc=(acc<op) zero-extended.
  - E GTU: acc=(acc>op) zero-extended.
  - F UNDO.
- Multi-cycle ops. k = operand[$clog2(WIDTH)-1:0].
  - 5 SHL k, 6 SHR k (logical), 7 SAR k (arithmetic). One bit per cycle. k=0 completes as a single-cycle op.
  - B MUL: low WIDTH bits of acc*op by shift-add. Exactly WIDTH BUSY cycles.
  - acc and flags hold their old values throughout BUSY. They update on the BUSY->IDLE edge, and op_ready is 1 in that same cycle.
- Flags, computed on the result:
  - Z = result==0; N = result MSB.
  - ADD: C = carry out; V = signed overflow (operand signs equal, result sign differs).
  - SUB: C = borrow (op > acc unsigned); V = signed overflow.
  - NEG: V = 1 iff acc was the minimum signed value; C = (acc != 0).
  - Shifts: C = last bit shifted out (0 for k=0); V = 0.
  - MUL: V = 1 iff the upper WIDTH bits of the full product are non-zero; C = 0.
  - Logic, REV, LOAD, compare: C = V = 0.
- Undo history:
  - Every accepted non-UNDO op pushes the pre-op {acc, flags} at accept.
  - When full, a push overwrites the oldest entry (circular) and undo_count stays at UNDO_DEPTH.
  - UNDO with undo_count>0 pops the newest entry into acc/flags and decrements undo_count.
  - UNDO with undo_count==0 pulses err for 1 cycle; acc and flags are unchanged.
- err is otherwise 0.

Decomposition:
- Package calc_pkg holds:
  - the opcode enum (OP_ADD..OP_UNDO);
  - the flag index constants (FLG_C=3, FLG_V=2, FLG_N=1, FLG_Z=0);
  - the state enum {IDLE, BUSY};
  - a packed struct undo_entry_t {acc, flags} parametrised via the module's WIDTH.
- One sub-module, calc_undo_stack: circular LIFO with push/pop/count and overwrite-oldest on full, parameters WIDTH and UNDO_DEPTH.

Test Plan:
1. Reset; LOAD 0x7F; ADD 0x01 -> acc=0x80, flags C=0,V=1,N=1,Z=0; op_ready stays 1.
2. LOAD 0x05; SUB 0x05 -> acc=0x00, Z=1,C=0. Then SUB 0x01 -> acc=0xFF, C=1,N=1,V=0.
3. LOAD 0x12; MUL 0x10 -> op_ready=0 for exactly 8 cycles, acc reads 0x12 throughout. Final acc=0x20, V=1,C=0. An op_valid pulse during BUSY is not accepted.
4. LOAD 0x81; SHL 3 -> op_ready=0 for 3 cycles; acc=0x08, C=0. Then LOAD 0x80; SAR 2 -> acc=0xE0, N=1. SHR 0 -> single cycle, acc=0xE0, C=0.
5. UNDO_DEPTH=4: LOAD 1..6 -> undo_count=4. Five UNDOs -> acc 5,4,3,2, then err pulse with acc staying 2 and undo_count=0.
6. Assert rst_n low 4 cycles into a MUL -> acc=0, flags=0, undo_count=0 immediately. op_ready=1 after release; the next ADD 0x03 gives acc=0x03.
